// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   - FSM state encoding (2-bit IDLE / BUSY_I / BUSY_D)
//   - grant-owner encoding (GNT_IF / GNT_D)
//   - pick_grant(): chooses the owner of the next transaction in IDLE
package mem_port_arbiter_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_BUSY_I = BUSY_I,
    ST_BUSY_D = BUSY_D
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

  // Only meaningful when at least one request is pending. A lone requester
  // always wins; on a conflict the data side wins unless prefer_if is set
  // (round-robin build, data side owned the previous grant).
  function automatic gnt_t pick_grant(input logic if_req, input logic d_req,
                                      input logic prefer_if);
    return (if_req && (!d_req || prefer_if)) ? GNT_IF : GNT_D;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake/bus signal around the arbiter.
//   IF side  : if_req, if_addr -> if_ack, if_rdata, if_stall
//   D side   : d_req, d_we, d_addr, d_wdata -> d_ack, d_rdata, d_stall
//   Memory   : mem_valid, mem_we, mem_addr, mem_wdata -> mem_rdy, mem_rdata
// Modports:
//   slave  - the arbiter itself (serves the stages, drives the memory)
//   master - the environment: pipeline requesters plus the memory model
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rdy;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdy, mem_rdata,
    output if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
           mem_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdy, mem_rdata,
    input  if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
           mem_valid, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// mem_arb_sat_counter: up-counter that sticks at all-ones.
//   clk, rst_n : clock, async active-low reset (clears to 0)
//   en         : count request for this cycle
//   cnt        : current value
module mem_arb_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (en && (cnt != '1))
      cnt <= cnt + WIDTH'(1);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// the instruction-fetch stage (read-only) and the MEM stage (read/write).
// One transaction at a time; acks are one-cycle registered pulses and the
// stall outputs are req && !ack.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus (slave)   : requester and memory handshakes, see mem_port_arbiter_if
//   conflict_cnt  : saturating count of IDLE cycles with both requests pending
//
// Build option
//   MEM_ARB_RR_EN : when defined, conflicts are resolved round-robin
//                   (opposite of the last grant); otherwise the data side
//                   always wins a conflict.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0] conflict_cnt
);

  arb_state_t state, state_nxt;
  gnt_t       gnt_sel;
  logic       grant;      // IDLE with a request: start a transaction this edge
  logic       done;       // BUSY with mem_rdy: retire the transaction this edge
  logic       prefer_if;
  logic       conflict;

  logic              mem_valid_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ack_q, d_ack_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

`ifdef MEM_ARB_RR_EN
  gnt_t last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= GNT_IF;
    else if (grant)
      last_grant <= gnt_sel;
  end

  assign prefer_if = (last_grant == GNT_D);
`else
  assign prefer_if = 1'b0;
`endif

  assign gnt_sel  = pick_grant(bus.if_req, bus.d_req, prefer_if);
  assign conflict = (state == ST_IDLE) && bus.if_req && bus.d_req;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // mem_rdy outside BUSY is not ours and is dropped here.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          grant     = 1'b1;
          state_nxt = (gnt_sel == GNT_IF) ? ST_BUSY_I : ST_BUSY_D;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (bus.mem_rdy) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  // The memory request is a latched copy, so requester inputs may wander
  // while BUSY without disturbing the memory. The ack cycle is IDLE, so a
  // request still asserted there is granted immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      if (grant) begin
        mem_valid_q <= 1'b1;
        if (gnt_sel == GNT_D) begin
          mem_we_q    <= bus.d_we;
          mem_addr_q  <= bus.d_addr;
          mem_wdata_q <= bus.d_wdata;
        end else begin
          mem_we_q    <= 1'b0;
          mem_addr_q  <= bus.if_addr;
        end
      end else if (done) begin
        mem_valid_q <= 1'b0;
        mem_we_q    <= 1'b0;
        if (state == ST_BUSY_I) begin
          if_ack_q   <= 1'b1;
          if_rdata_q <= bus.mem_rdata;
        end else begin
          d_ack_q <= 1'b1;
          // a store leaves the last load value visible
          if (!mem_we_q)
            d_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;

  // Stall every cycle of a request except the one carrying its ack.
  assign bus.if_stall  = bus.if_req && !if_ack_q;
  assign bus.d_stall   = bus.d_req  && !d_ack_q;

  // ------------------------------------------------------ conflict count
  mem_arb_sat_counter #(.WIDTH(CNT_W)) u_conflict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (conflict),
    .cnt   (conflict_cnt)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Directed scenarios followed by a
// randomized run against a transaction-level reference model. The counter is
// built 8 bits wide here so saturation is reachable in a short run.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] conflict_cnt;
  int               total = 0;
  int               bad = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdy = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) step();
    total++; if ({bus.if_ack, bus.d_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks: got %b want 00", {bus.if_ack, bus.d_ack}); end
    total++; if ({bus.mem_valid, bus.mem_we} !== 2'b00) begin bad++; $display("FAIL reset_memctl: got %b want 00", {bus.mem_valid, bus.mem_we}); end
    total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
    total++; if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", bus.if_rdata, bus.d_rdata); end
    total++; if (conflict_cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %h want 0", conflict_cnt); end
    rst_n = 1'b1;
    step();
    total++; if (bus.mem_valid !== 1'b0) begin bad++; $display("FAIL idle_no_req: got mem_valid=%b want 0", bus.mem_valid); end
  endtask

  // IF read of 0x40, memory answers after 3 wait cycles.
  task automatic test_if_read();
    int stalls = 0;
    int ack_c = -1;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    for (int c = 0; c < 12 && ack_c < 0; c++) begin
      bus.mem_rdy   = (c == 4);
      bus.mem_rdata = (c == 4) ? 32'h2008_0005 : 32'hFFFF_0000 + 32'(c);
      #1;
      if (bus.if_stall) stalls++;
      if (c == 2) begin
        total++; if ({bus.mem_valid, bus.mem_we} !== 2'b10 || bus.mem_addr !== 32'h40) begin bad++; $display("FAIL if_memreq: got v/we=%b addr=%h want 10/00000040", {bus.mem_valid, bus.mem_we}, bus.mem_addr); end
      end
      step();
      if (bus.if_ack) ack_c = c + 1;
    end
    bus.mem_rdy = 1'b0;
    #1;
    total++; if (ack_c !== 5) begin bad++; $display("FAIL if_ack_cycle: got %0d want 5", ack_c); end
    total++; if (bus.if_rdata !== 32'h2008_0005) begin bad++; $display("FAIL if_rdata: got %h want 20080005", bus.if_rdata); end
    total++; if (bus.if_stall !== 1'b0) begin bad++; $display("FAIL if_stall_ack_cycle: got %b want 0", bus.if_stall); end
    total++; if (stalls !== 5) begin bad++; $display("FAIL if_stall_count: got %0d want 5", stalls); end
    bus.if_req = 1'b0;
    step();
    total++; if ({bus.if_ack, bus.mem_valid} !== 2'b00) begin bad++; $display("FAIL if_ack_pulse: got ack/valid=%b want 00", {bus.if_ack, bus.mem_valid}); end
  endtask

  // Simultaneous requests, zero-wait memory returning addr ^ 0xA5A50000.
  task automatic test_conflict();
    bit order[$];
    logic [3:0] seq;
    logic [3:0] exp_seq;
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
    for (int c = 0; c < 20 && order.size() < 2; c++) begin
      bus.mem_rdy = bus.mem_valid; bus.mem_rdata = bus.mem_addr ^ 32'hA5A5_0000;
      step();
      if (bus.d_ack) begin
        order.push_back(1'b1); bus.d_req = 1'b0;
        total++; if (bus.d_rdata !== 32'hA5A5_0080) begin bad++; $display("FAIL conflict_d_rdata: got %h want a5a50080", bus.d_rdata); end
      end
      if (bus.if_ack) begin
        order.push_back(1'b0); bus.if_req = 1'b0;
        total++; if (bus.if_rdata !== 32'hA5A5_0044) begin bad++; $display("FAIL conflict_if_rdata: got %h want a5a50044", bus.if_rdata); end
      end
    end
    bus.mem_rdy = 1'b0;
    total++; if (order.size() != 2 || order[0] !== 1'b1 || order[1] !== 1'b0) begin bad++; $display("FAIL conflict_order: got n=%0d want D then IF", order.size()); end
    total++; if (conflict_cnt !== 8'd1) begin bad++; $display("FAIL conflict_cnt1: got %0d want 1", conflict_cnt); end
    // Both held across four grants.
    order.delete();
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      bus.mem_rdy = bus.mem_valid; bus.mem_rdata = bus.mem_addr ^ 32'hA5A5_0000;
      step();
      if (bus.d_ack) order.push_back(1'b1);
      if (bus.if_ack) order.push_back(1'b0);
      if (order.size() >= 4) begin bus.if_req = 1'b0; bus.d_req = 1'b0; end
    end
    bus.mem_rdy = 1'b0;
    seq = '0;
    foreach (order[i]) if (i < 4) seq[3-i] = order[i];
    exp_seq = RR_BUILD ? 4'b1010 : 4'b1111;
    total++; if (order.size() != 4 || seq !== exp_seq) begin bad++; $display("FAIL repeat_grants: got n=%0d seq=%b want %b (1=D)", order.size(), seq, exp_seq); end
    total++; if (conflict_cnt !== 8'd5) begin bad++; $display("FAIL conflict_cnt5: got %0d want 5", conflict_cnt); end
    step();
  endtask

  // Zero-wait store of 0xDEADBEEF to 0x100; d_rdata keeps the last load.
  task automatic test_d_write();
    int ack_c = -1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 8 && ack_c < 0; c++) begin
      bus.mem_rdy = (c == 1); bus.mem_rdata = 32'h1234_5678;
      #1;
      if (c == 1) begin
        total++; if ({bus.mem_valid, bus.mem_we} !== 2'b11 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL d_write_req: got v/we=%b addr=%h wdata=%h want 11/00000100/deadbeef", {bus.mem_valid, bus.mem_we}, bus.mem_addr, bus.mem_wdata); end
      end
      step();
      if (bus.d_ack) ack_c = c + 1;
    end
    total++; if (ack_c !== 2) begin bad++; $display("FAIL d_write_latency: got %0d want 2", ack_c); end
    total++; if (bus.d_rdata !== 32'hA5A5_0080) begin bad++; $display("FAIL d_write_rdata: got %h want a5a50080", bus.d_rdata); end
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.mem_rdy = 1'b0;
    step();
    total++; if (bus.d_ack !== 1'b0) begin bad++; $display("FAIL d_ack_pulse: got %b want 0", bus.d_ack); end
  endtask

  // Load from 0x100; requester scribbles on addr/we mid-transaction.
  task automatic test_addr_change();
    int ack_c = -1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    for (int c = 0; c < 12 && ack_c < 0; c++) begin
      bus.mem_rdy = (c == 4); bus.mem_rdata = (c == 4) ? 32'h5555_AAAA : 32'h0;
      if (c == 2) begin bus.d_addr = 32'h200; bus.d_we = 1'b1; bus.d_wdata = 32'h0BAD_0BAD; end
      #1;
      if (c >= 1 && c <= 4) begin
        total++; if (bus.mem_addr !== 32'h100 || {bus.mem_valid, bus.mem_we} !== 2'b10) begin bad++; $display("FAIL addr_hold c%0d: got addr=%h v/we=%b want 00000100/10", c, bus.mem_addr, {bus.mem_valid, bus.mem_we}); end
      end
      step();
      if (bus.d_ack) ack_c = c + 1;
    end
    total++; if (ack_c !== 5 || bus.d_rdata !== 32'h5555_AAAA) begin bad++; $display("FAIL addr_change_rdata: got cyc=%0d data=%h want 5/5555aaaa", ack_c, bus.d_rdata); end
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.mem_rdy = 1'b0;
    step();
  endtask

  // Counter starts at 5; each held-conflict grant adds one until all-ones.
  task automatic test_saturation();
    int acks = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h8; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'hC;
    for (int c = 0; c < 1200 && acks < 260; c++) begin
      bus.mem_rdy = bus.mem_valid;
      step();
      if (bus.if_ack || bus.d_ack) begin
        acks++;
        if (acks == 200) begin
          total++; if (conflict_cnt !== 8'd205) begin bad++; $display("FAIL cnt_before_sat: got %0d want 205", conflict_cnt); end
        end
      end
    end
    total++; if (acks !== 260) begin bad++; $display("FAIL sat_timeout: got %0d acks want 260", acks); end
    total++; if (conflict_cnt !== {CNT_W{1'b1}}) begin bad++; $display("FAIL cnt_saturated: got %h want ff", conflict_cnt); end
    bus.mem_rdy = 1'b0;
    repeat (20) step();
    total++; if (conflict_cnt !== {CNT_W{1'b1}} || bus.mem_valid !== 1'b1) begin bad++; $display("FAIL cnt_hold: got %h valid=%b want ff/1", conflict_cnt, bus.mem_valid); end
    bus.mem_rdy = 1'b1;
    step();
    bus.mem_rdy = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (2) step();
  endtask

  // Async reset while a store is outstanding; late mem_rdy must not ack.
  task automatic test_reset_mid_busy();
    bit seen = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h3C; bus.d_wdata = 32'h0F0F_0F0F;
    step();
    total++; if ({bus.mem_valid, bus.mem_we} !== 2'b11) begin bad++; $display("FAIL busy_d_before_reset: got %b want 11", {bus.mem_valid, bus.mem_we}); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus.mem_valid, bus.mem_we, bus.if_ack, bus.d_ack} !== 4'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL async_reset_mem: got v/we/ia/da=%b addr=%h wdata=%h want 0", {bus.mem_valid, bus.mem_we, bus.if_ack, bus.d_ack}, bus.mem_addr, bus.mem_wdata); end
    total++; if ({bus.if_rdata, bus.d_rdata} !== 64'h0 || conflict_cnt !== '0) begin bad++; $display("FAIL async_reset_regs: got %h/%h cnt=%h want 0", bus.if_rdata, bus.d_rdata, conflict_cnt); end
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    step();
    rst_n = 1'b1;
    bus.mem_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      bus.mem_rdy = 1'b0;
      if (bus.d_ack || bus.if_ack || bus.mem_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL ghost_ack: got activity=%b want 0", seen); end
  endtask

  function automatic logic [31:0] raddr();
    return 32'($urandom_range(0, 7)) << 2;
  endfunction

  // Random traffic against a transaction-level model: one owner at a time,
  // grants by the priority rule, read data from a reference memory image.
  task automatic test_random(input int cycles);
    logic [31:0] tmem [0:7];
    logic [31:0] rmem [0:7];
    bit busy = 1'b0, owner_d = 1'b0, last_d = 1'b0;
    bit t_we = 1'b0;
    logic [31:0] t_addr = '0, t_wdata = '0;
    int wait_n = 0;
    logic [CNT_W-1:0] e_cnt = '0;
    logic [31:0] e_if_rdata = '0, e_d_rdata = '0;
    bit e_if_ack, e_d_ack;
    bit p_if = 1'b0, p_d = 1'b0, p_rdy = 1'b0, p_dwe = 1'b0;
    logic [31:0] p_ia = '0, p_da = '0, p_dw = '0;
    for (int i = 0; i < 8; i++) begin tmem[i] = $urandom; rmem[i] = tmem[i]; end
    drive_idle();
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      e_if_ack = 1'b0; e_d_ack = 1'b0;
      if (!busy) begin
        if (p_if && p_d && e_cnt != {CNT_W{1'b1}}) e_cnt++;
        if (p_if || p_d) begin
          owner_d = p_d && (!p_if || !(RR_BUILD && last_d));
          last_d  = owner_d;
          busy    = 1'b1;
          t_we    = owner_d ? p_dwe : 1'b0;
          t_addr  = owner_d ? p_da : p_ia;
          t_wdata = p_dw;
          wait_n  = $urandom_range(0, 3);
        end
      end else if (p_rdy) begin
        busy = 1'b0;
        if (owner_d) begin
          e_d_ack = 1'b1;
          if (t_we) rmem[t_addr[4:2]] = t_wdata;
          else e_d_rdata = rmem[t_addr[4:2]];
        end else begin
          e_if_ack = 1'b1;
          e_if_rdata = rmem[t_addr[4:2]];
        end
      end
      total++; if (bus.mem_valid !== busy) begin bad++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.mem_valid, busy); end
      if (busy) begin
        total++; if (bus.mem_addr !== t_addr || bus.mem_we !== t_we) begin bad++; $display("FAIL rnd_memreq c%0d: got %h/%b want %h/%b", c, bus.mem_addr, bus.mem_we, t_addr, t_we); end
        if (t_we) begin
          total++; if (bus.mem_wdata !== t_wdata) begin bad++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, bus.mem_wdata, t_wdata); end
        end
      end
      total++; if ({bus.if_ack, bus.d_ack} !== {e_if_ack, e_d_ack}) begin bad++; $display("FAIL rnd_ack c%0d: got %b want %b", c, {bus.if_ack, bus.d_ack}, {e_if_ack, e_d_ack}); end
      total++; if (bus.if_rdata !== e_if_rdata || bus.d_rdata !== e_d_rdata) begin bad++; $display("FAIL rnd_rdata c%0d: got %h/%h want %h/%h", c, bus.if_rdata, bus.d_rdata, e_if_rdata, e_d_rdata); end
      total++; if (conflict_cnt !== e_cnt) begin bad++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, conflict_cnt, e_cnt); end
      // IF requester
      if (e_if_ack) begin
        bus.if_req = ($urandom_range(0, 3) == 0);
        bus.if_addr = raddr();
      end else if (!bus.if_req) begin
        if ($urandom_range(0, 1) == 1) begin bus.if_req = 1'b1; bus.if_addr = raddr(); end
      end else if (busy && !owner_d && $urandom_range(0, 2) == 0) begin
        bus.if_addr = $urandom;
      end
      // D requester
      if (e_d_ack || !bus.d_req) begin
        bus.d_req = e_d_ack ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
        bus.d_we = $urandom_range(0, 1) == 1; bus.d_addr = raddr(); bus.d_wdata = $urandom;
      end else if (busy && owner_d && $urandom_range(0, 2) == 0) begin
        bus.d_we = ~bus.d_we; bus.d_addr = $urandom; bus.d_wdata = $urandom;
      end
      // memory: completes after wait_n cycles; stray rdy while idle
      if (busy && wait_n == 0) begin
        bus.mem_rdy = 1'b1;
        bus.mem_rdata = tmem[bus.mem_addr[4:2]];
        if (bus.mem_we) tmem[bus.mem_addr[4:2]] = bus.mem_wdata;
      end else begin
        if (busy) wait_n--;
        bus.mem_rdy = !busy && ($urandom_range(0, 7) == 0);
        bus.mem_rdata = $urandom;
      end
      p_if = bus.if_req; p_ia = bus.if_addr;
      p_d = bus.d_req; p_dwe = bus.d_we; p_da = bus.d_addr; p_dw = bus.d_wdata;
      p_rdy = bus.mem_rdy;
      #1;
      total++; if ({bus.if_stall, bus.d_stall} !== {bus.if_req && !e_if_ack, bus.d_req && !e_d_ack}) begin bad++; $display("FAIL rnd_stall c%0d: got %b want %b", c, {bus.if_stall, bus.d_stall}, {bus.if_req && !e_if_ack, bus.d_req && !e_d_ack}); end
    end
    drive_idle();
    repeat (6) step();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_if_read();
    test_conflict();
    test_d_write();
    test_addr_change();
    test_saturation();
    test_reset_mid_busy();
    test_random(1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
